vga_rect_compositor: RTL and testbench

Parametrised successor to the fixed 640x480 square demo. Integrates the pixel-strobe divider, a timing generator with configurable porch and sync values, and N_RECT run-time-programmable, prioritised, coloured rectangles. Rectangle registers are double-buffered and commit once per frame, so updates never tear. Sits directly under the board top; drives the VGA pins.

---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_timing.sv | 85 ++++++++
 rtl/vga_rect_compositor.sv | 207 ++++++++++++++++++++
 tb/tb_vga_rect_compositor.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the rectangle compositor and its timing generator:
//   - default 640x480@60 timing constants and divider / rectangle defaults
//   - rect_t, the per-rectangle record held in the shadow and active banks
//   - line_total(), which gives H_TOTAL / V_TOTAL from the four widths
//   - idx_width(), the rectangle index width (never narrower than 1 bit)
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam bit SYNC_POL_DEF = 1'b0;
    localparam int CLK_DIV_DEF  = 4;
    localparam int N_RECT_DEF   = 4;
    localparam int CW_DEF       = 4;

    // The colour field is sized for the widest channel we support, so a
    // compositor built with CW <= MAX_CW uses only the low 3*CW bits.
    localparam int MAX_CW  = 8;
    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t                x0;
        coord_t                x1;
        coord_t                y0;
        coord_t                y1;
        logic [3*MAX_CW-1:0]   rgb;
        logic                  vis;
    } rect_t;

    function automatic int line_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing
// Pixel-strobe divider plus horizontal / vertical counters for a VGA raster.
// Ports:
//   clk, rst_n   : system clock, synchronous active-low reset
//   stb          : pixel strobe, high one clk in every CLK_DIV
//   hc, vc       : current column / line counters (advance on stb only)
//   hs, vs       : raw sync-window flags (1 = inside sync window)
//   de           : raw active-video flag
//   commit       : high on the strobe that closes the last visible line
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int CLK_DIV  = CLK_DIV_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    output logic   stb,
    output coord_t hc,
    output coord_t vc,
    output logic   hs,
    output logic   vs,
    output logic   de,
    output logic   commit
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS      = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS      = coord_t'(V_ACTIVE);
    localparam coord_t V_VIS_LAST = coord_t'(V_ACTIVE - 1);
    localparam coord_t HS_START   = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END     = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START   = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END     = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div;
    logic [DW-1:0] div_next;

    always_comb begin
        div_next = (div == DIV_LAST) ? '0 : div + DW'(1);
    end

    // The strobe is registered from the next divider value so it is a clean
    // flop output and stays low while reset is held, even for CLK_DIV=1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div <= '0;
            stb <= 1'b0;
            hc  <= '0;
            vc  <= '0;
        end else begin
            div <= div_next;
            stb <= (div_next == DIV_LAST);
            if (stb) begin
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? '0 : vc + coord_t'(1);
                end else begin
                    hc <= hc + coord_t'(1);
                end
            end
        end
    end

    always_comb begin
        hs     = (hc >= HS_START) && (hc < HS_END);
        vs     = (vc >= VS_START) && (vc < VS_END);
        de     = (hc < H_VIS) && (vc < V_VIS);
        commit = stb && (hc == H_LAST) && (vc == V_VIS_LAST);
    end

endmodule

// File: rtl/vga_rect_compositor.sv
// vga_rect_compositor
// VGA raster generator compositing N_RECT prioritised, coloured rectangles
// over a background colour. Rectangles are written into a shadow bank at
// any time and copied to the displayed bank once per frame, just after the
// last visible line, so a frame never shows a half-updated set.
// Ports:
//   i_clk, i_rst_n        : system clock, synchronous active-low reset
//   i_wr_en               : one-cycle write strobe into the shadow bank
//   i_wr_idx              : rectangle slot (slots >= N_RECT are ignored)
//   i_wr_x0/x1, y0/y1     : half-open bounds [x0,x1) x [y0,y1)
//   i_wr_rgb, i_wr_vis    : colour {r,g,b} and enable
//   o_pix_stb             : pixel strobe
//   o_hs, o_vs, o_de      : syncs and active video
//   o_x, o_y              : coordinate of the pixel currently on o_r/g/b
//   o_r, o_g, o_b         : colour channels
//   o_frame               : one-cycle pulse after each bank commit
module vga_rect_compositor
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE = H_ACTIVE_DEF,
    parameter int          H_FP     = H_FP_DEF,
    parameter int          H_SYNC   = H_SYNC_DEF,
    parameter int          H_BP     = H_BP_DEF,
    parameter int          V_ACTIVE = V_ACTIVE_DEF,
    parameter int          V_FP     = V_FP_DEF,
    parameter int          V_SYNC   = V_SYNC_DEF,
    parameter int          V_BP     = V_BP_DEF,
    parameter bit          SYNC_POL = SYNC_POL_DEF,
    parameter int          CLK_DIV  = CLK_DIV_DEF,
    parameter int          N_RECT   = N_RECT_DEF,
    parameter int          CW       = CW_DEF,
    parameter logic [3*CW-1:0] BG   = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_wr_en,
    input  logic [idx_width(N_RECT)-1:0] i_wr_idx,
    input  logic [9:0]                   i_wr_x0,
    input  logic [9:0]                   i_wr_x1,
    input  logic [9:0]                   i_wr_y0,
    input  logic [9:0]                   i_wr_y1,
    input  logic [3*CW-1:0]              i_wr_rgb,
    input  logic                         i_wr_vis,
    output logic                         o_pix_stb,
    output logic                         o_hs,
    output logic                         o_vs,
    output logic                         o_de,
    output logic [9:0]                   o_x,
    output logic [9:0]                   o_y,
    output logic [CW-1:0]                o_r,
    output logic [CW-1:0]                o_g,
    output logic [CW-1:0]                o_b,
    output logic                         o_frame
);

    localparam int IW = idx_width(N_RECT);

    logic   stb;
    coord_t hc;
    coord_t vc;
    logic   hs_raw;
    logic   vs_raw;
    logic   de_raw;
    logic   commit;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV)
    ) u_timing (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .stb    (stb),
        .hc     (hc),
        .vc     (vc),
        .hs     (hs_raw),
        .vs     (vs_raw),
        .de     (de_raw),
        .commit (commit)
    );

    rect_t shadow [N_RECT];
    rect_t active [N_RECT];
    rect_t wr_rect;

    always_comb begin
        wr_rect                 = '0;
        wr_rect.x0              = i_wr_x0;
        wr_rect.x1              = i_wr_x1;
        wr_rect.y0              = i_wr_y0;
        wr_rect.y1              = i_wr_y1;
        wr_rect.rgb[3*CW-1:0]   = i_wr_rgb;
        wr_rect.vis             = i_wr_vis;
    end

    // A write landing on the commit clock only reaches the shadow bank: the
    // active bank copies the shadow contents from before that edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_RECT; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            o_frame <= 1'b0;
        end else begin
            for (int i = 0; i < N_RECT; i++) begin
                if (i_wr_en && (i_wr_idx == IW'(i))) begin
                    shadow[i] <= wr_rect;
                end
                if (commit) begin
                    active[i] <= shadow[i];
                end
            end
            o_frame <= commit;
        end
    end

    logic [N_RECT-1:0] hit;

    // Inverted or zero-width bounds can never satisfy both compares, so
    // empty rectangles need no special case.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N_RECT; i++) begin
            hit[i] = active[i].vis
                     && (hc >= active[i].x0) && (hc < active[i].x1)
                     && (vc >= active[i].y0) && (vc < active[i].y1);
        end
    end

    logic [N_RECT-1:0] s1_hit;
    logic              s1_hs;
    logic              s1_vs;
    logic              s1_de;
    coord_t            s1_x;
    coord_t            s1_y;
    logic [3*CW-1:0]   s2_rgb;
    logic              s2_hs;
    logic              s2_vs;
    logic              s2_de;
    coord_t            s2_x;
    coord_t            s2_y;
    logic [3*CW-1:0]   pick;

    // Walking from the highest index down lets the lowest hitting index
    // overwrite everything above it.
    always_comb begin
        pick = BG;
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (s1_hit[i]) begin
                pick = active[i].rgb[3*CW-1:0];
            end
        end
        if (!s1_de) begin
            pick = '0;
        end
    end

    // Sync flags travel as "asserted" bits so the pipeline resets to zero;
    // polarity is applied only at the pins.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_hit <= '0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_de  <= 1'b0;
            s1_x   <= '0;
            s1_y   <= '0;
            s2_rgb <= '0;
            s2_hs  <= 1'b0;
            s2_vs  <= 1'b0;
            s2_de  <= 1'b0;
            s2_x   <= '0;
            s2_y   <= '0;
        end else if (stb) begin
            s1_hit <= hit;
            s1_hs  <= hs_raw;
            s1_vs  <= vs_raw;
            s1_de  <= de_raw;
            s1_x   <= hc;
            s1_y   <= vc;
            s2_rgb <= pick;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_de  <= s1_de;
            s2_x   <= s1_x;
            s2_y   <= s1_y;
        end
    end

    assign o_pix_stb = stb;
    assign o_hs      = s2_hs ? SYNC_POL : ~SYNC_POL;
    assign o_vs      = s2_vs ? SYNC_POL : ~SYNC_POL;
    assign o_de      = s2_de;
    assign o_x       = s2_x;
    assign o_y       = s2_y;
    assign o_r       = s2_rgb[3*CW-1 -: CW];
    assign o_g       = s2_rgb[2*CW-1 -: CW];
    assign o_b       = s2_rgb[CW-1:0];

endmodule

// File: tb/tb_vga_rect_compositor.sv
// tb_vga_rect_compositor
// Self-checking bench for vga_rect_compositor on a shrunken raster. The
// expected picture is derived from the clock count since reset release:
// strobe number, raster position and displayed rectangle set all follow
// from plain arithmetic, and every output is compared on every falling edge.
module tb_vga_rect_compositor;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 12, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int D  = 2;
    localparam int NR = 3;
    localparam int CW = 4;
    localparam logic [11:0] BGC = 12'h35A;
    localparam int FRAME_CYC = FT * D;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [9:0]  wr_x0, wr_x1, wr_y0, wr_y1;
    logic [11:0] wr_rgb;
    logic        wr_vis;
    logic        pix_stb, hs, vs, de, frame;
    logic [9:0]  x, y;
    logic [3:0]  r, g, b;

    always #5 clk = ~clk;

    vga_rect_compositor #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0), .CLK_DIV (D), .N_RECT (NR), .CW (CW), .BG (BGC)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (wr_en),
        .i_wr_idx  (wr_idx),
        .i_wr_x0   (wr_x0),
        .i_wr_x1   (wr_x1),
        .i_wr_y0   (wr_y0),
        .i_wr_y1   (wr_y1),
        .i_wr_rgb  (wr_rgb),
        .i_wr_vis  (wr_vis),
        .o_pix_stb (pix_stb),
        .o_hs      (hs),
        .o_vs      (vs),
        .o_de      (de),
        .o_x       (x),
        .o_y       (y),
        .o_r       (r),
        .o_g       (g),
        .o_b       (b),
        .o_frame   (frame)
    );

    typedef struct {
        int x0;
        int x1;
        int y0;
        int y1;
        int rgb;
        bit vis;
    } model_rect_t;

    model_rect_t shadow_m [NR];
    model_rect_t shown_m  [NR];
    int          edge_cnt = 0;
    bit          frame_exp = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    // Commits happen on the strobe whose pre-edge raster position is the
    // last pixel of line VA-1, i.e. on strobe numbers VA*HT + k*FT.
    function automatic bit isCommitEdge(input int e);
        int s;
        s = e / D;
        return (e % D == 0) && (s >= VA * HT) && ((s - VA * HT) % FT == 0);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            edge_cnt  <= 0;
            frame_exp <= 1'b0;
            for (int i = 0; i < NR; i++) begin
                shadow_m[i] <= '{default: 0};
                shown_m[i]  <= '{default: 0};
            end
        end else begin
            edge_cnt  <= edge_cnt + 1;
            frame_exp <= isCommitEdge(edge_cnt + 1);
            if (isCommitEdge(edge_cnt + 1)) begin
                for (int i = 0; i < NR; i++) shown_m[i] <= shadow_m[i];
            end
            if (wr_en && int'(wr_idx) < NR) begin
                shadow_m[int'(wr_idx)] <= '{int'(wr_x0), int'(wr_x1), int'(wr_y0),
                                             int'(wr_y1), int'(wr_rgb), wr_vis};
            end
        end
    end

    function automatic logic [11:0] pixelColour(input int px, input int py);
        for (int i = 0; i < NR; i++) begin
            if (shown_m[i].vis && px >= shown_m[i].x0 && px < shown_m[i].x1
                && py >= shown_m[i].y0 && py < shown_m[i].y1)
                return 12'(shown_m[i].rgb);
        end
        return BGC;
    endfunction

    function automatic logic [36:0] expectedOutputs();
        int s, p, px, py;
        logic stb_e, de_e, hs_a, vs_a;
        logic [11:0] c;
        stb_e = (edge_cnt > 0) && (edge_cnt % D == D - 1);
        s = edge_cnt / D;
        if (s < 2) return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000, stb_e, frame_exp};
        p  = (s - 2) % FT;
        px = p % HT;
        py = p / HT;
        de_e = (px < HA) && (py < VA);
        hs_a = (px >= HA + HF) && (px < HA + HF + HS);
        vs_a = (py >= VA + VF) && (py < VA + VF + VS);
        c = de_e ? pixelColour(px, py) : 12'h000;
        return {10'(px), 10'(py), de_e, ~hs_a, ~vs_a, c, stb_e, frame_exp};
    endfunction

    task automatic checkOutput(input string tag);
        logic [36:0] obs_v, exp_v;
        obs_v = {x, y, de, hs, vs, r, g, b, pix_stb, frame};
        exp_v = expectedOutputs();
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("[TB] FAIL %s edge=%0d observed={x,y,de,hs,vs,rgb,stb,frame}=%h expected=%h",
                   tag, edge_cnt, obs_v, exp_v);
        end
    endtask

    task automatic runCycles(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            checkOutput(tag);
        end
    endtask

    task automatic applyStimulus(input int idx, input int x0, input int x1,
                                 input int y0, input int y1, input logic [11:0] rgb,
                                 input bit vis, input string tag);
        wr_en  = 1'b1;
        wr_idx = 2'(idx);
        wr_x0  = 10'(x0);
        wr_x1  = 10'(x1);
        wr_y0  = 10'(y0);
        wr_y1  = 10'(y1);
        wr_rgb = rgb;
        wr_vis = vis;
        runCycles(1, tag);
        wr_en  = 1'b0;
    endtask

    task automatic expectCount(input int observed, input int expected, input string tag);
        vectors++;
        assert (observed == expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic frameStats();
        int n_stb = 0, n_de = 0, n_hs = 0, n_vs = 0;
        repeat (FRAME_CYC) begin
            @(negedge clk);
            checkOutput("frame_scan");
            if (pix_stb) begin
                n_stb++;
                if (de) n_de++;
                if (!hs) n_hs++;
                if (!vs) n_vs++;
            end
        end
        expectCount(n_stb, FT, "strobe_count");
        expectCount(n_de, HA * VA, "de_count");
        expectCount(n_hs, HS * VT, "hsync_count");
        expectCount(n_vs, VS * HT, "vsync_count");
    endtask

    task automatic waitBeforeCommit(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 2 * FRAME_CYC && !found; i++) begin
            if (isCommitEdge(edge_cnt + 1)) found = 1'b1;
            else runCycles(1, tag);
        end
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("[TB] FAIL %s_timeout observed=no_commit expected=commit", tag);
        end
    endtask

    task automatic waitRasterPos(input int pos, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 2 * FRAME_CYC && !found; i++) begin
            if (edge_cnt % D == 0 && (edge_cnt / D) % FT == pos) found = 1'b1;
            else runCycles(1, tag);
        end
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("[TB] FAIL %s_timeout observed=not_reached expected=pos%0d", tag, pos);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        wr_en  = 1'b0;
        wr_idx = '0;
        wr_x0  = '0;
        wr_x1  = '0;
        wr_y0  = '0;
        wr_y1  = '0;
        wr_rgb = '0;
        wr_vis = 1'b0;
        repeat (3) @(posedge clk);
        runCycles(3, "reset_values");
        rst_n = 1'b1;
        runCycles(10, "startup");
        frameStats();

        $display("[TB] single red rectangle");
        applyStimulus(0, 4, 10, 3, 5, 12'hF00, 1'b1, "wr_rect0");
        runCycles(2 * FRAME_CYC, "rect0_red");

        $display("[TB] overlap priority and hide");
        applyStimulus(1, 4, 10, 3, 5, 12'h00F, 1'b1, "wr_rect1");
        runCycles(FRAME_CYC + 7, "overlap");
        applyStimulus(0, 4, 10, 3, 5, 12'hF00, 1'b0, "hide_rect0");
        runCycles(2 * FRAME_CYC, "rect1_blue");

        $display("[TB] write on the commit clock");
        waitBeforeCommit("wait_commit");
        applyStimulus(1, 2, 8, 1, 9, 12'h0F0, 1'b1, "wr_on_commit");
        runCycles(2 * FRAME_CYC + 9, "after_commit_write");

        $display("[TB] empty rectangle and out-of-range slot");
        applyStimulus(2, 6, 6, 0, 12, 12'hFFF, 1'b1, "wr_empty");
        applyStimulus(3, 0, 16, 0, 12, 12'hABC, 1'b1, "wr_idx_oob");
        runCycles(2 * FRAME_CYC, "empty_oob");

        $display("[TB] reset mid-frame");
        waitRasterPos(6 * HT + 8, "wait_mid");
        rst_n = 1'b0;
        runCycles(1, "mid_reset_values");
        rst_n = 1'b1;
        runCycles(FRAME_CYC + 11, "after_mid_reset");

        $display("[TB] randomized rectangles");
        repeat (6) begin
            repeat ($urandom_range(1, 3)) begin
                applyStimulus($urandom_range(0, 3), $urandom_range(0, HT),
                              $urandom_range(0, HT), $urandom_range(0, VT),
                              $urandom_range(0, VT), 12'($urandom),
                              1'($urandom_range(0, 3) != 0), "wr_random");
                runCycles($urandom_range(0, 40), "random_gap");
            end
            runCycles($urandom_range(FRAME_CYC, 2 * FRAME_CYC), "random_run");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
